// File: rtl/paint_pkg.sv
// Shared paint-pipeline definitions: canvas size, colour codes and brush speed states.
// frame_buffer decodes color_t, so its encoding must stay fixed.
package paint_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 360;

    typedef enum logic [3:0] {
        BLACK = 4'd0,
        WHITE = 4'd1,
        RED   = 4'd2,
        GREEN = 4'd3,
        BLUE  = 4'd4
    } color_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_MAX  = 2'd2
    } speed_state_t;

    function automatic color_t next_color(input color_t c);
        return (c == BLUE) ? BLACK : color_t'(c + 4'd1);
    endfunction

endpackage

// File: rtl/axis_stepper.sv
// Combinational single-axis step: moves a coordinate by +/-speed and clamps it to 0..LIMIT-1.
module axis_stepper #(
    parameter int unsigned LIMIT   = 640,
    parameter int unsigned W       = 10,
    parameter int unsigned SPEED_W = 4
) (
    input  logic [W-1:0]       coord_in,
    input  logic signed [1:0]  dir_in,
    input  logic [SPEED_W-1:0] speed_in,
    output logic [W-1:0]       coord_out
);

    localparam logic signed [11:0] MAX_C = 12'(LIMIT - 1);

    logic signed [11:0] w_pos;
    logic signed [11:0] w_step;
    logic signed [11:0] w_sum;

    // 12-bit signed headroom keeps both underflow and overflow visible to the clamp.
    assign w_pos  = $signed(12'(coord_in));
    assign w_step = $signed(12'(speed_in));

    always_comb begin
        w_sum = w_pos;
        case (dir_in)
            2'b01:   w_sum = w_pos + w_step;
            2'b11:   w_sum = w_pos - w_step;
            default: w_sum = w_pos;
        endcase
    end

    always_comb begin
        coord_out = w_sum[W-1:0];
        if (w_sum < 12'sd0) begin
            coord_out = '0;
        end else if (w_sum > MAX_C) begin
            coord_out = MAX_C[W-1:0];
        end
    end

endmodule

// File: rtl/brush_controller.sv
// Per-frame brush state: accelerating cursor, colour cycling, pen and size latches.
// Every output changes only in the cycle after an nf_in pulse.
module brush_controller #(
    parameter int unsigned H_ACTIVE     = paint_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE     = paint_pkg::V_ACTIVE,
    parameter int unsigned MAX_STEP     = 8,
    parameter int unsigned ACCEL_FRAMES = 4
) (
    input  logic       pixel_clk_in,
    input  logic       rst_n_in,
    input  logic       nf_in,
    input  logic [3:0] dir_btn_in,
    input  logic       draw_btn_in,
    input  logic       color_btn_in,
    input  logic [2:0] sw_in,
    output logic [9:0] x_out,
    output logic [8:0] y_out,
    output logic [3:0] color_out,
    output logic [2:0] sw_out,
    output logic       brush_en_out
);

    import paint_pkg::*;

    localparam int unsigned SPEED_W = $clog2(MAX_STEP + 1);
    localparam int unsigned CNT_W   = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [SPEED_W-1:0] SPEED_ONE = SPEED_W'(1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_STEP);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ACCEL_FRAMES - 1);
    localparam logic [9:0]         X_RST     = 10'(H_ACTIVE / 2);
    localparam logic [8:0]         Y_RST     = 9'(V_ACTIVE / 2);

    logic [9:0]         r_x;
    logic [8:0]         r_y;
    color_t             r_color;
    logic [2:0]         r_sw;
    logic               r_en;
    logic               r_pend;
    logic               r_color_prev;
    speed_state_t       r_state;
    logic [SPEED_W-1:0] r_speed;
    logic [CNT_W-1:0]   r_cnt;

    logic signed [1:0]  w_dx;
    logic signed [1:0]  w_dy;
    logic               w_moving;
    logic               w_color_edge;
    logic [9:0]         w_x_next;
    logic [8:0]         w_y_next;
    speed_state_t       w_state_d;
    logic [SPEED_W-1:0] w_speed_d;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [SPEED_W-1:0] w_base_speed;
    logic [CNT_W-1:0]   w_base_cnt;

    // dir_btn_in = {up, down, left, right}
    assign w_dx = $signed({1'b0, dir_btn_in[0]}) - $signed({1'b0, dir_btn_in[1]});
    assign w_dy = $signed({1'b0, dir_btn_in[2]}) - $signed({1'b0, dir_btn_in[3]});
    assign w_moving     = (w_dx != 2'sd0) || (w_dy != 2'sd0);
    assign w_color_edge = color_btn_in & ~r_color_prev;

    axis_stepper #(
        .LIMIT   (H_ACTIVE),
        .W       (10),
        .SPEED_W (SPEED_W)
    ) u_step_x (
        .coord_in  (r_x),
        .dir_in    (w_dx),
        .speed_in  (r_speed),
        .coord_out (w_x_next)
    );

    axis_stepper #(
        .LIMIT   (V_ACTIVE),
        .W       (9),
        .SPEED_W (SPEED_W)
    ) u_step_y (
        .coord_in  (r_y),
        .dir_in    (w_dy),
        .speed_in  (r_speed),
        .coord_out (w_y_next)
    );

    // The frame that starts a hold counts as its first held frame.
    always_comb begin
        w_state_d    = r_state;
        w_speed_d    = r_speed;
        w_cnt_d      = r_cnt;
        w_base_speed = (r_state == S_IDLE) ? SPEED_ONE : r_speed;
        w_base_cnt   = (r_state == S_IDLE) ? '0 : r_cnt;
        if (!w_moving) begin
            w_state_d = S_IDLE;
            w_speed_d = SPEED_ONE;
            w_cnt_d   = '0;
        end else if (r_state != S_MAX) begin
            w_speed_d = w_base_speed;
            w_cnt_d   = w_base_cnt + CNT_W'(1);
            if (w_base_cnt == CNT_LAST) begin
                w_cnt_d = '0;
                if (w_base_speed < SPEED_MAX) begin
                    w_speed_d = w_base_speed + SPEED_ONE;
                end
            end
            w_state_d = (w_speed_d >= SPEED_MAX) ? S_MAX : S_HOLD;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_x          <= X_RST;
            r_y          <= Y_RST;
            r_color      <= WHITE;
            r_sw         <= '0;
            r_en         <= 1'b0;
            r_pend       <= 1'b0;
            r_color_prev <= 1'b0;
            r_state      <= S_IDLE;
            r_speed      <= SPEED_ONE;
            r_cnt        <= '0;
        end else begin
            r_color_prev <= color_btn_in;
            if (nf_in) begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_sw    <= sw_in;
                r_en    <= draw_btn_in;
                r_state <= w_state_d;
                r_speed <= w_speed_d;
                r_cnt   <= w_cnt_d;
                r_pend  <= 1'b0;
                if (r_pend || w_color_edge) begin
                    r_color <= next_color(r_color);
                end
            end else if (w_color_edge) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign x_out        = r_x;
    assign y_out        = r_y;
    assign color_out    = r_color;
    assign sw_out       = r_sw;
    assign brush_en_out = r_en;

endmodule
